// File: rtl/cond_exec_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cond_exec_ctrl_pkg
// Purpose  : Shared constants for conditional execution. Contains the 4-bit
//            condition codes, the {z, c, n, v} flag layout and the default
//            depth of the in-flight flag-writer counter.
// Revision : 1.0 - initial release
// ============================================================================
package cond_exec_ctrl_pkg;

    // Condition codes carried in the ID instruction
    localparam logic [3:0] C_COND_EQ = 4'b0000;  // z
    localparam logic [3:0] C_COND_NE = 4'b0001;  // !z
    localparam logic [3:0] C_COND_CS = 4'b0010;  // c
    localparam logic [3:0] C_COND_CC = 4'b0011;  // !c
    localparam logic [3:0] C_COND_MI = 4'b0100;  // n
    localparam logic [3:0] C_COND_PL = 4'b0101;  // !n
    localparam logic [3:0] C_COND_VS = 4'b0110;  // v
    localparam logic [3:0] C_COND_VC = 4'b0111;  // !v
    localparam logic [3:0] C_COND_HI = 4'b1000;  // c & !z
    localparam logic [3:0] C_COND_LS = 4'b1001;  // !c | z
    localparam logic [3:0] C_COND_GE = 4'b1010;  // n == v
    localparam logic [3:0] C_COND_LT = 4'b1011;  // n != v
    localparam logic [3:0] C_COND_GT = 4'b1100;  // !z & n == v
    localparam logic [3:0] C_COND_LE = 4'b1101;  // z | n != v
    localparam logic [3:0] C_COND_AL = 4'b1110;  // always
    localparam logic [3:0] C_COND_NV = 4'b1111;  // never

    // Bit positions inside the 4-bit status word {z, c, n, v}
    localparam int C_FLAG_Z = 3;
    localparam int C_FLAG_C = 2;
    localparam int C_FLAG_N = 1;
    localparam int C_FLAG_V = 0;

    // Default in-flight flag-writer limit and the matching counter width
    localparam int C_PENDING_MAX_DFLT = 3;
    localparam int C_PENDING_W_DFLT   = 2;

    // Status word viewed as named flags; field order matches the bit positions
    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic v;
    } flags_t;

endpackage
`default_nettype wire

// File: rtl/cond_exec_ctrl_eval.sv
`default_nettype none
// ============================================================================
// Module   : cond_exec_ctrl_eval
// Purpose  : Shared combinational condition evaluator. The upper three code
//            bits select a base test, the lowest bit inverts it; the 111x
//            pair is special-cased as always / never.
// Revision : 1.0 - initial release
// ============================================================================
module cond_exec_ctrl_eval
    import cond_exec_ctrl_pkg::*;
(
    input  logic [3:0] i_cond,
    input  flags_t     i_flags,
    output logic       o_pass
);

    logic w_base;

    // Base test selected by the code pair; odd codes are the negation
    always_comb begin
        w_base = 1'b1;
        case (i_cond[3:1])
            3'd0:    w_base = i_flags.z;
            3'd1:    w_base = i_flags.c;
            3'd2:    w_base = i_flags.n;
            3'd3:    w_base = i_flags.v;
            3'd4:    w_base = i_flags.c & ~i_flags.z;
            3'd5:    w_base = (i_flags.n == i_flags.v);
            3'd6:    w_base = ~i_flags.z & (i_flags.n == i_flags.v);
            default: w_base = 1'b1;
        endcase
    end

    // 1110 passes, 1111 never passes; all other codes invert on bit 0
    assign o_pass = (i_cond[3:1] == 3'd7) ? ~i_cond[0] : (w_base ^ i_cond[0]);

endmodule
`default_nettype wire

// File: rtl/cond_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cond_exec_ctrl
// Purpose  : Owns the {z, c, n, v} status register, counts in-flight
//            flag-setting instructions and schedules the ID instruction as
//            stalled, executed or squashed.
//            Optional macro COND_FLAG_BYPASS_EN: when the last outstanding
//            flag writer commits, ID is evaluated against the incoming status
//            and issues in the same cycle instead of waiting one cycle.
//            PENDING_W must satisfy 2**PENDING_W > PENDING_MAX.
// Revision : 1.0 - initial release
// ============================================================================
module cond_exec_ctrl
    import cond_exec_ctrl_pkg::*;
#(
    parameter int PENDING_MAX = C_PENDING_MAX_DFLT,
    parameter int PENDING_W   = C_PENDING_W_DFLT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [3:0]           id_cond,
    input  logic                 id_s,
    input  logic                 exe_status_we,
    input  logic [3:0]           exe_status,
    input  logic                 flush,
    output logic                 stall,
    output logic                 id_exec,
    output logic                 id_squash,
    output logic [3:0]           status,
    output logic [PENDING_W-1:0] pending,
    output logic                 err
);

    localparam logic [PENDING_W-1:0] C_PEND_MAX = PENDING_W'(PENDING_MAX);
    localparam logic [PENDING_W-1:0] C_PEND_ONE = PENDING_W'(1);

    logic [3:0]           r_status;
    logic [PENDING_W-1:0] r_pending;
    logic                 r_err;

    logic   w_pend_nz;
    logic   w_pend_full;
    logic   w_bypass;
    logic   w_pass;
    logic   w_stall;
    logic   w_fire;
    logic   w_inc;
    logic   w_dec;
    flags_t w_eval_flags;

    assign w_pend_nz   = (r_pending != '0);
    assign w_pend_full = (r_pending == C_PEND_MAX);

`ifdef COND_FLAG_BYPASS_EN
    // The last outstanding writer is committing now: its value is final
    assign w_bypass     = exe_status_we & (r_pending == C_PEND_ONE) & ~flush;
    assign w_eval_flags = w_bypass ? flags_t'(exe_status) : flags_t'(r_status);
`else
    assign w_bypass     = 1'b0;
    assign w_eval_flags = flags_t'(r_status);
`endif

    cond_exec_ctrl_eval u_eval (
        .i_cond  (id_cond),
        .i_flags (w_eval_flags),
        .o_pass  (w_pass)
    );

    // AL never reads flags, so only conditional instructions wait on writers
    assign w_stall = id_valid & ~flush &
                     ((w_pend_nz & (id_cond != C_COND_AL) & ~w_bypass) |
                      (id_s & w_pend_full));

    assign w_fire = id_valid & ~w_stall & ~flush;
    assign w_inc  = w_fire & w_pass & id_s;
    assign w_dec  = exe_status_we;

    // Status register: EXE write lands even during a flush (older instruction)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_status <= 4'b0000;
        end else if (exe_status_we) begin
            r_status <= exe_status;
        end
    end

    // In-flight writer counter with saturation and sticky error on misuse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= '0;
            r_err     <= 1'b0;
        end else if (flush) begin
            r_pending <= '0;
        end else if (w_inc && !w_dec) begin
            if (w_pend_full) begin
                r_err <= 1'b1;
            end else begin
                r_pending <= r_pending + C_PEND_ONE;
            end
        end else if (w_dec && !w_inc) begin
            if (!w_pend_nz) begin
                r_err <= 1'b1;
            end else begin
                r_pending <= r_pending - C_PEND_ONE;
            end
        end
    end

    assign stall     = w_stall;
    assign id_exec   = w_fire & w_pass;
    assign id_squash = w_fire & ~w_pass;
    assign status    = r_status;
    assign pending   = r_pending;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: doc/cond_exec_ctrl.md
Name: cond_exec_ctrl

Overview:
- Owns the architectural status register {z, c, n, v} and schedules conditional execution of the instruction in ID.
- Tracks in-flight flag-setting instructions (S bit) with a pending counter.
- Stalls ID when its condition depends on flags not yet written, then issues it as executed or squashed.
- Sits between the ID stage, the EXE/ALU status write-back and the hazard/flush logic; instantiates the shared condition evaluator.

Parameters:
- PENDING_MAX, 3, maximum in-flight flag-setting instructions.
- PENDING_W, 2, width of the pending counter; must satisfy 2^PENDING_W > PENDING_MAX.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds an instruction.
- id_cond  in  4  condition field of the ID instruction (codes from Constants.v).
- id_s  in  1  ID instruction updates flags.
- exe_status_we  in  1  single-cycle status write from EXE.
- exe_status  in  4  new {z, c, n, v}.
- flush  in  1  pipeline flush (branch taken).
- stall  out  1  hold ID and earlier stages.
- id_exec  out  1  ID instruction issues and executes.
- id_squash  out  1  ID instruction issues as NOP (condition failed).
- status  out  4  registered {z, c, n, v}.
- pending  out  PENDING_W  in-flight flag-writer count.
- err  out  1  sticky counter under/overflow.

Behaviour:
- Reset (rst low, async): status = 0, pending = 0, err = 0. With id_valid = 0, stall, id_exec and id_squash are all 0.
- Condition evaluation:
  - cond_pass is combinational: shared evaluator applied to (id_cond, status).
  - AL always passes.
  - 4'b1111 never passes.
- Stall:
  - stall = id_valid & ~flush & ((pending != 0 & id_cond != AL) | (id_s & pending == PENDING_MAX)).
  - stall is combinational.
- Issue:
  - fire = id_valid & ~stall & ~flush.
  - id_exec = fire & cond_pass.
  - id_squash = fire & ~cond_pass.
  - Exactly one of the two is high when fire is high.
- Pending counter:
  - inc = id_exec & id_s. Squashed instructions never count.
  - dec = exe_status_we.
  - inc and dec together: count unchanged.
  - dec at 0: count stays 0, err set.
  - inc at PENDING_MAX: blocked by stall. If it is reached anyway, count saturates and err is set.
- Status write: status <= exe_status on the clock edge after exe_status_we is sampled. It is visible to cond_pass in the next cycle (1-cycle latency).
- Flush:
  - pending <= 0; no issue that cycle.
  - A simultaneous exe_status_we still writes status (the older instruction commits).
- err: sticky until reset.
- A mid-operation reset discards pending writes and status immediately.

Optional Feature:
- Macro: COND_FLAG_BYPASS_EN.
- Enabled: when exe_status_we = 1 and pending == 1 and flush = 0:
  - id_cond is evaluated against exe_status instead of status;
  - the pending != 0 stall term is suppressed that cycle;
  - issue happens in the same cycle as the write.
- Disabled: ID stalls until status is updated, i.e. one extra cycle.

Decomposition:
- Condition codes and {z, c, n, v} bit positions stay in Constants.v; add a PENDING_MAX default there.
- Sub-module: the existing condition evaluator, instantiated once. With COND_FLAG_BYPASS_EN it is fed a muxed status.
- Counter and status register stay inline.

Test Plan:
- Reset: hold rst = 0 with id_valid = 1, id_cond = EQ → status = 0, pending = 0, err = 0. After release → id_squash = 1 (z = 0).
- Stall:
  - Issue an AL instruction with id_s = 1 → pending = 1.
  - Next cycle id_cond = EQ → stall = 1.
  - exe_status_we with exe_status = 4'b1000 → without bypass, stall drops one cycle later and id_exec = 1.
  - With bypass, id_exec = 1 in the write cycle.
- Saturation: three back-to-back AL + id_s issues with no writes → pending = 3. Fourth id_s → stall = 1, err stays 0.
- Simultaneous events: inc and exe_status_we in the same cycle with pending = 1 → pending stays 1, status updated.
- Flush: flush = 1 with pending = 2 and exe_status_we = 1, exe_status = 4'b0100 → pending = 0, status = 4'b0100, no id_exec/id_squash.
- Underflow and evaluation:
  - exe_status_we with pending = 0 → err = 1 and stays 1.
  - Evaluation with status n = 1, v = 1: GE → id_exec; LT → id_squash.
